// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the Mini-SRC register-register ALU sequencer.
//   - opcode encodings as seen in IR[31:27]
//   - sequencer state encoding (IDLE, T0..T6)
//   - opcode classification helpers used by the FSM decode
package src_ctrl_pkg;

   localparam logic [4:0] OPC_ADD  = 5'b00000;
   localparam logic [4:0] OPC_SUB  = 5'b00001;
   localparam logic [4:0] OPC_AND  = 5'b00010;
   localparam logic [4:0] OPC_OR   = 5'b00011;
   localparam logic [4:0] OPC_SHR  = 5'b00100;
   localparam logic [4:0] OPC_SHRA = 5'b00101;
   localparam logic [4:0] OPC_SHL  = 5'b00110;
   localparam logic [4:0] OPC_ROR  = 5'b00111;
   localparam logic [4:0] OPC_ROL  = 5'b01000;
   localparam logic [4:0] OPC_MUL  = 5'b01111;
   localparam logic [4:0] OPC_DIV  = 5'b10000;
   localparam logic [4:0] OPC_NEG  = 5'b10001;
   localparam logic [4:0] OPC_NOT  = 5'b10010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6
   } state_t;

   function automatic logic is_supported(input logic [4:0] opc);
      case (opc)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHRA, OPC_SHL,
         OPC_ROR, OPC_ROL, OPC_MUL, OPC_DIV, OPC_NEG, OPC_NOT: is_supported = 1'b1;
         default:                                             is_supported = 1'b0;
      endcase
   endfunction

   // Unary ops take their single operand from Rb; Rc is ignored.
   function automatic logic is_unary(input logic [4:0] opc);
      is_unary = (opc == OPC_NEG) || (opc == OPC_NOT);
   endfunction

   // mul/div produce a 64-bit result that needs the extra HI write-back step.
   function automatic logic is_wide(input logic [4:0] opc);
      is_wide = (opc == OPC_MUL) || (opc == OPC_DIV);
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder for register enable vectors.
//   idx  in   IDX_W     register index
//   en   in   1         gate; 0 forces the vector to all zeros
//   vec  out  NUM_REGS  one-hot vector, bit idx set when en=1 and idx < NUM_REGS
module onehot_decoder #(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic [IDX_W-1:0]    idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] vec
);

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         vec[i] = en && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Hardwired control sequencer for Mini-SRC register-register ALU instructions.
// Fetch T0-T2, execute T3-T5, plus T6 for the HI half of mul/div results.
//   clock        in   1           system clock, rising edge
//   clear        in   1           asynchronous active-low reset
//   start        in   1           begin fetch+execute (sampled in IDLE only)
//   mem_ready    in   1           memory data valid; T1 waits for it
//   ir           in   32          IR contents: opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   r_in, r_out  out  NUM_REGS    one-hot register load / bus-drive enables
//   pc_out .. lo_in out 1 each    datapath control strobes
//   alu_control  out  ALU_CTRL_W  ALU operation select
//   busy, done, illegal out 1     status
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC (first cycle only), memory read into MDR until mem_ready
// T2    | MDR -> IR
// T3    | decode IR, Rb -> Y (or flag illegal and abort)
// T4    | Y op Rc (or op Rb for unary) -> Z
// T5    | ZLO -> Ra (or -> LO for mul/div)
// T6    | ZHI -> HI (mul/div only)
module reg_alu_sequencer
   import src_ctrl_pkg::*;
#(
   parameter int NUM_REGS     = 16,
   parameter int REG_IDX_W    = 4,
   parameter int ALU_CTRL_W   = 5,
   parameter int AUTO_REFETCH = 0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  mem_ready,
   input  logic [31:0]           ir,
   output logic [NUM_REGS-1:0]   r_in,
   output logic [NUM_REGS-1:0]   r_out,
   output logic                  pc_out,
   output logic                  mar_in,
   output logic                  inc_pc,
   output logic                  pc_in,
   output logic                  read,
   output logic                  mdr_in,
   output logic                  mdr_out,
   output logic                  ir_in,
   output logic                  y_in,
   output logic                  z_in,
   output logic                  zlow_out,
   output logic                  zhigh_out,
   output logic                  hi_in,
   output logic                  lo_in,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal
);

   state_t state, state_nxt;

   logic [4:0]           opc_q;
   logic [REG_IDX_W-1:0] ra_q, rb_q, rc_q;
   logic                 t1_first_q;

   logic [4:0]           opc_ir;
   logic [REG_IDX_W-1:0] ra_ir, rb_ir, rc_ir;
   logic                 ir_legal;
   logic                 unused_ir_bits;

   logic                 r_in_en, r_out_en;
   logic [REG_IDX_W-1:0] r_out_idx;

   state_t after_done;

   function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
      idx_ok = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == REG_IDX_W'(i)) idx_ok = 1'b1;
      end
   endfunction

   assign opc_ir = ir[31:27];
   assign ra_ir  = ir[26 -: REG_IDX_W];
   assign rb_ir  = ir[22 -: REG_IDX_W];
   assign rc_ir  = ir[18 -: REG_IDX_W];
   assign unused_ir_bits = ^ir[14:0];

   assign ir_legal = is_supported(opc_ir) && idx_ok(ra_ir) && idx_ok(rb_ir) && idx_ok(rc_ir);

   assign after_done = (AUTO_REFETCH != 0) ? ST_T0 : ST_IDLE;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state      <= ST_IDLE;
         opc_q      <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         rc_q       <= '0;
         t1_first_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         // Only the T0->T1 transition marks the first T1 cycle, so pc_in
         // fires once no matter how long the memory wait lasts.
         t1_first_q <= (state == ST_T0);
         if (state == ST_T3) begin
            opc_q <= opc_ir;
            ra_q  <= ra_ir;
            rb_q  <= rb_ir;
            rc_q  <= rc_ir;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_T0;
         ST_T0:   state_nxt = ST_T1;
         ST_T1:   if (mem_ready) state_nxt = ST_T2;
         ST_T2:   state_nxt = ST_T3;
         ST_T3:   state_nxt = ir_legal ? ST_T4 : ST_IDLE;
         ST_T4:   state_nxt = ST_T5;
         ST_T5:   state_nxt = is_wide(opc_q) ? ST_T6 : after_done;
         ST_T6:   state_nxt = after_done;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_out      = 1'b0;
      mar_in      = 1'b0;
      inc_pc      = 1'b0;
      pc_in       = 1'b0;
      read        = 1'b0;
      mdr_in      = 1'b0;
      mdr_out     = 1'b0;
      ir_in       = 1'b0;
      y_in        = 1'b0;
      z_in        = 1'b0;
      zlow_out    = 1'b0;
      zhigh_out   = 1'b0;
      hi_in       = 1'b0;
      lo_in       = 1'b0;
      alu_control = '0;
      done        = 1'b0;
      illegal     = 1'b0;
      r_in_en     = 1'b0;
      r_out_en    = 1'b0;
      r_out_idx   = rb_q;
      busy        = (state != ST_IDLE);
      case (state)
         ST_T0: begin
            pc_out      = 1'b1;
            mar_in      = 1'b1;
            inc_pc      = 1'b1;
            z_in        = 1'b1;
            alu_control = ALU_CTRL_W'(OPC_ADD);
         end
         ST_T1: begin
            zlow_out = 1'b1;
            pc_in    = t1_first_q;
            read     = 1'b1;
            mdr_in   = 1'b1;
         end
         ST_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         ST_T3: begin
            // Fields are not latched yet, so decode straight from IR.
            r_out_idx = rb_ir;
            r_out_en  = ir_legal;
            y_in      = ir_legal;
            illegal   = !ir_legal;
         end
         ST_T4: begin
            alu_control = ALU_CTRL_W'(opc_q);
            z_in        = 1'b1;
            r_out_idx   = is_unary(opc_q) ? rb_q : rc_q;
            r_out_en    = 1'b1;
         end
         ST_T5: begin
            zlow_out = 1'b1;
            if (is_wide(opc_q)) begin
               lo_in = 1'b1;
            end else begin
               r_in_en = 1'b1;
               done    = 1'b1;
            end
         end
         ST_T6: begin
            zhigh_out = 1'b1;
            hi_in     = 1'b1;
            done      = 1'b1;
         end
         default: ;
      endcase
   end

   onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_r_in_dec (
      .idx (ra_q),
      .en  (r_in_en),
      .vec (r_in)
   );

   onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_r_out_dec (
      .idx (r_out_idx),
      .en  (r_out_en),
      .vec (r_out)
   );

endmodule

// File: tb/tb_reg_alu_sequencer.sv
module tb_reg_alu_sequencer;

   typedef struct packed {
      logic [15:0] r_in;
      logic [15:0] r_out;
      logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
      logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
      logic [4:0] alu;
      logic busy, done, illegal;
   } ctl_t;

   localparam ctl_t IDLE_V = '0;
   localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5, S_T5 = 6, S_T6 = 7;

   logic clock = 1'b0;
   logic clear, start, mem_ready;
   logic [31:0] ir;

   logic [15:0] m_r_in, m_r_out, a_r_in, a_r_out;
   logic m_pc_out, m_mar_in, m_inc_pc, m_pc_in, m_read, m_mdr_in, m_mdr_out, m_ir_in;
   logic m_y_in, m_z_in, m_zlow_out, m_zhigh_out, m_hi_in, m_lo_in, m_busy, m_done, m_illegal;
   logic a_pc_out, a_mar_in, a_inc_pc, a_pc_in, a_read, a_mdr_in, a_mdr_out, a_ir_in;
   logic a_y_in, a_z_in, a_zlow_out, a_zhigh_out, a_hi_in, a_lo_in, a_busy, a_done, a_illegal;
   logic [4:0] m_alu, a_alu;

   ctl_t act_m, act_a, exp_m, exp_a;
   ctl_t trace[$];
   bit   chk_m, chk_a, rec_en;
   int   total = 0;
   int   bad = 0;

   assign act_m = {m_r_in, m_r_out, m_pc_out, m_mar_in, m_inc_pc, m_pc_in, m_read, m_mdr_in,
                   m_mdr_out, m_ir_in, m_y_in, m_z_in, m_zlow_out, m_zhigh_out, m_hi_in, m_lo_in,
                   m_alu, m_busy, m_done, m_illegal};
   assign act_a = {a_r_in, a_r_out, a_pc_out, a_mar_in, a_inc_pc, a_pc_in, a_read, a_mdr_in,
                   a_mdr_out, a_ir_in, a_y_in, a_z_in, a_zlow_out, a_zhigh_out, a_hi_in, a_lo_in,
                   a_alu, a_busy, a_done, a_illegal};

   reg_alu_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .ALU_CTRL_W(5), .AUTO_REFETCH(0)) dut (
      .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
      .r_in(m_r_in), .r_out(m_r_out), .pc_out(m_pc_out), .mar_in(m_mar_in), .inc_pc(m_inc_pc),
      .pc_in(m_pc_in), .read(m_read), .mdr_in(m_mdr_in), .mdr_out(m_mdr_out), .ir_in(m_ir_in),
      .y_in(m_y_in), .z_in(m_z_in), .zlow_out(m_zlow_out), .zhigh_out(m_zhigh_out),
      .hi_in(m_hi_in), .lo_in(m_lo_in), .alu_control(m_alu), .busy(m_busy), .done(m_done),
      .illegal(m_illegal)
   );

   reg_alu_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .ALU_CTRL_W(5), .AUTO_REFETCH(1)) dut_ar (
      .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
      .r_in(a_r_in), .r_out(a_r_out), .pc_out(a_pc_out), .mar_in(a_mar_in), .inc_pc(a_inc_pc),
      .pc_in(a_pc_in), .read(a_read), .mdr_in(a_mdr_in), .mdr_out(a_mdr_out), .ir_in(a_ir_in),
      .y_in(a_y_in), .z_in(a_z_in), .zlow_out(a_zlow_out), .zhigh_out(a_zhigh_out),
      .hi_in(a_hi_in), .lo_in(a_lo_in), .alu_control(a_alu), .busy(a_busy), .done(a_done),
      .illegal(a_illegal)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit opc_ok(input logic [4:0] o);
      logic [4:0] legal [13];
      legal = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd16, 5'd17, 5'd18};
      opc_ok = 1'b0;
      foreach (legal[i]) if (legal[i] == o) opc_ok = 1'b1;
   endfunction

   function automatic bit opc_unary(input logic [4:0] o);
      opc_unary = (o == 5'd17) || (o == 5'd18);
   endfunction

   function automatic bit opc_wide(input logic [4:0] o);
      opc_wide = (o == 5'd15) || (o == 5'd16);
   endfunction

   // Expected control word for a given step of an instruction.
   function automatic ctl_t expv(input int s, input logic [31:0] ins, input bit first);
      ctl_t e;
      logic [4:0] o;
      int ra, rb, rc;
      e  = '0;
      o  = ins[31:27];
      ra = int'(ins[26:23]);
      rb = int'(ins[22:19]);
      rc = int'(ins[18:15]);
      e.busy = (s != S_IDLE);
      case (s)
         S_T0: begin e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; end
         S_T1: begin e.zlow_out = 1; e.pc_in = first; e.read = 1; e.mdr_in = 1; end
         S_T2: begin e.mdr_out = 1; e.ir_in = 1; end
         S_T3: begin
            if (opc_ok(o)) begin e.r_out[rb] = 1'b1; e.y_in = 1; end
            else e.illegal = 1;
         end
         S_T4: begin
            e.alu = o;
            e.z_in = 1;
            if (opc_unary(o)) e.r_out[rb] = 1'b1;
            else e.r_out[rc] = 1'b1;
         end
         S_T5: begin
            e.zlow_out = 1;
            if (opc_wide(o)) e.lo_in = 1;
            else begin e.r_in[ra] = 1'b1; e.done = 1; end
         end
         S_T6: begin e.zhigh_out = 1; e.hi_in = 1; e.done = 1; end
         default: ;
      endcase
      return e;
   endfunction

   always @(negedge clock) begin
      if (chk_m) begin
         total++;
         if (act_m !== exp_m) begin
            bad++;
            $display("FAIL main_cycle t=%0t got=%h want=%h", $time, act_m, exp_m);
         end
      end
      if (chk_a) begin
         total++;
         if (act_a !== exp_a) begin
            bad++;
            $display("FAIL refetch_cycle t=%0t got=%h want=%h", $time, act_a, exp_a);
         end
      end
      if (rec_en) trace.push_back(act_m);
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic idle_cyc(input bit st);
      start     = st;
      mem_ready = 1'($urandom_range(0, 1));
      ir        = $urandom;
      exp_m     = IDLE_V;
      exp_a     = IDLE_V;
      @(posedge clock); #1;
   endtask

   // Drive one instruction from T0 on; m_on/a_on select which DUT is expected to follow it.
   task automatic run_seq(input logic [31:0] ins, input int wait_n, input bit m_on,
                          input bit a_on, input int stop_after);
      int seq[$];
      int t1n;
      int s;
      bit first;
      seq = {S_T0};
      repeat (wait_n + 1) seq.push_back(S_T1);
      seq.push_back(S_T2);
      seq.push_back(S_T3);
      if (opc_ok(ins[31:27])) begin
         seq.push_back(S_T4);
         seq.push_back(S_T5);
         if (opc_wide(ins[31:27])) seq.push_back(S_T6);
      end
      t1n = 0;
      for (int k = 0; k < seq.size() && k < stop_after; k++) begin
         s = seq[k];
         first = (s == S_T1) && (t1n == 0);
         if (s == S_T1) begin
            mem_ready = (t1n == wait_n);
            t1n++;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         ir    = (s == S_T3) ? ins : $urandom;
         start = m_on ? 1'($urandom_range(0, 1)) : 1'b0;
         exp_m = m_on ? expv(s, ins, first) : IDLE_V;
         exp_a = a_on ? expv(s, ins, first) : IDLE_V;
         @(posedge clock); #1;
      end
   endtask

   task automatic run_rec(input logic [31:0] ins, input int wait_n);
      trace.delete();
      rec_en = 1;
      idle_cyc(1);
      run_seq(ins, wait_n, 1, 0, 99);
      idle_cyc(0);
      rec_en = 0;
   endtask

   function automatic int count_field(input int which);
      int n = 0;
      foreach (trace[i]) begin
         case (which)
            0: n += int'(trace[i].read);
            1: n += int'(trace[i].pc_in);
            default: n += int'(trace[i].busy);
         endcase
      end
      return n;
   endfunction

   initial begin
      logic [31:0] ins;
      logic [4:0]  o;
      logic [4:0]  legal_list [13];
      legal_list = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd16, 5'd17, 5'd18};
      clear = 0; start = 0; mem_ready = 0; ir = 0;
      chk_m = 0; chk_a = 0; rec_en = 0;
      exp_m = IDLE_V; exp_a = IDLE_V;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_main", 64'(act_m), 64'(0));
      chk("reset_refetch", 64'(act_a), 64'(0));
      clear = 1;
      chk_m = 1;
      idle_cyc(0);

      // and R2,R5,R6
      run_rec(32'h112B0000, 0);
      chk("and_t3_rout", 64'(trace[4].r_out), 64'h0020);
      chk("and_t3_yin", 64'(trace[4].y_in), 64'd1);
      chk("and_t4_rout", 64'(trace[5].r_out), 64'h0040);
      chk("and_t4_alu", 64'(trace[5].alu), 64'b00010);
      chk("and_t5_rin", 64'(trace[6].r_in), 64'h0004);
      chk("and_t5_done", 64'({trace[6].done, trace[6].zlow_out}), 64'b11);

      // rol R7,R0,R4
      run_rec(32'h43820000, 0);
      chk("rol_t4_alu", 64'(trace[5].alu), 64'b01000);
      chk("rol_t4_rout", 64'(trace[5].r_out), 64'h0010);
      chk("rol_t5_rin", 64'(trace[6].r_in), 64'h0080);
      chk("rol_busy_falls", 64'(trace[7].busy), 64'd0);

      // mul R1,R3,R4
      run_rec({5'b01111, 4'd1, 4'd3, 4'd4, 15'd0}, 0);
      chk("mul_t5_lo", 64'({trace[6].lo_in, trace[6].zlow_out, trace[6].done}), 64'b110);
      chk("mul_t5_rin", 64'(trace[6].r_in), 64'h0);
      chk("mul_t6", 64'({trace[7].hi_in, trace[7].zhigh_out, trace[7].done}), 64'b111);
      chk("mul_busy_cycles", 64'(count_field(2)), 64'd7);

      // memory wait of 3 cycles in T1
      run_rec(32'h112B0000, 3);
      chk("wait_read_cycles", 64'(count_field(0)), 64'd4);
      chk("wait_pcin_pulses", 64'(count_field(1)), 64'd1);
      chk("wait_then_t2", 64'(trace[6].ir_in), 64'd1);

      // unsupported opcode
      run_rec({5'b11111, 27'h2B0000}, 0);
      chk("illegal_t3", 64'(trace[4].illegal), 64'd1);
      chk("illegal_no_drive", 64'({trace[4].r_out, trace[4].y_in}), 64'd0);
      chk("illegal_idle_next", 64'(trace[5].busy), 64'd0);

      // clear asserted in T4
      ins = 32'h112B0000;
      idle_cyc(1);
      run_seq(ins, 0, 1, 0, 4);
      exp_m = expv(S_T4, ins, 0);
      #2;
      clear = 0;
      #1;
      chk("clear_mid_t4", 64'(act_m), 64'd0);
      exp_m = IDLE_V;
      @(posedge clock); #1;
      clear = 1;
      idle_cyc(0);
      run_rec(32'h43820000, 1);
      chk("after_clear_t0", 64'({trace[1].pc_out, trace[1].mar_in, trace[1].inc_pc}), 64'b111);

      // randomized instruction stream
      repeat (150) begin
         if ($urandom_range(0, 9) < 8) o = legal_list[$urandom_range(0, 12)];
         else o = 5'($urandom_range(0, 31));
         ins = {o, 27'($urandom)};
         if ($urandom_range(0, 7) == 0) ins[22:19] = ins[26:23];
         if ($urandom_range(0, 7) == 0) ins[18:15] = ins[26:23];
         repeat ($urandom_range(0, 2)) idle_cyc(0);
         idle_cyc(1);
         run_seq(ins, $urandom_range(0, 3), 1, 0, 99);
      end
      idle_cyc(0);

      // AUTO_REFETCH instance: back-to-back instructions, ended by an illegal opcode
      clear = 0;
      @(posedge clock); #1;
      clear = 1;
      chk_a = 1;
      idle_cyc(1);
      run_seq(32'h112B0000, 0, 1, 1, 99);
      chk("refetch_t0_direct", 64'({act_a.pc_out, act_a.busy, act_m.busy}), 64'b110);
      run_seq({5'b01111, 4'd1, 4'd3, 4'd4, 15'd0}, 1, 0, 1, 99);
      run_seq({5'b11111, 27'h1234567}, 0, 0, 1, 99);
      idle_cyc(0);
      idle_cyc(0);
      chk_m = 0;
      chk_a = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
